// File: rtl/muldiv_pkg.sv
// Shared decode constants, FSM states and operand-sign helpers
// for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_BUSY,
        ST_FIXUP,
        ST_DONE
    } state_e;

    function automatic logic signed_a(input logic [2:0] f3);
        return f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic signed_b(input logic [2:0] f3);
        return f3 inside {F3_MULH, F3_DIV, F3_REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unit: shift-add multiply step or
// restoring compare-subtract-shift divide step.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 i_div,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [2*WIDTH-1:0]   i_prod,
    input  logic [WIDTH:0]       i_rem,
    output logic [2*WIDTH-1:0]   o_prod,
    output logic [WIDTH:0]       o_rem
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH+1:0] w_rsh;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;

    always_comb begin
        w_sum = {1'b0, i_prod[2*WIDTH-1:WIDTH]};
        if (i_prod[0]) begin
            w_sum = w_sum + {1'b0, i_a};
        end
        // Low half of i_prod holds the dividend; its MSB shifts into the remainder.
        w_rsh  = {i_rem, i_prod[WIDTH-1]};
        w_diff = w_rsh - {2'b00, i_b};
        w_ge   = ~w_diff[WIDTH+1];
        if (i_div) begin
            o_prod = {i_prod[2*WIDTH-1:WIDTH], i_prod[WIDTH-2:0], w_ge};
            o_rem  = w_ge ? w_diff[WIDTH:0] : w_rsh[WIDTH:0];
        end else begin
            o_prod = {w_sum, i_prod[WIDTH-1:1]};
            o_rem  = i_rem;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready handshake,
// one result bit per cycle, abort and asynchronous reset.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [31:0]      inst,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             z,
    output logic             n,
    output logic             illegal,
    output logic             busy
);

    state_e               r_state, w_nxt;
    logic [WIDTH-1:0]     r_a, r_b, r_out;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH:0]       r_rem;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_f3;
    logic                 r_sa, r_sb, r_ill, r_spec;

    logic                 w_ill_dec, w_div, w_sdiv, w_dz, w_ovf, w_spec;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b, w_spec_val;
    logic [WIDTH-1:0]     w_quo, w_remv, w_res;
    logic [2*WIDTH-1:0]   w_prod_s, w_step_prod;
    logic [WIDTH:0]       w_step_rem;
    logic                 w_unused;

    assign w_ill_dec = (inst[6:0] != OPC_OP) | (inst[31:25] != F7_MULDIV);
    assign w_div     = r_f3[2];
    assign w_sdiv    = r_f3[2] & ~r_f3[0];
    assign w_dz      = w_div & (r_b == '0);
    assign w_ovf     = w_sdiv & (r_a == {1'b1, {(WIDTH-1){1'b0}}}) & (&r_b);
    assign w_spec    = r_ill | w_dz | w_ovf;
    assign w_abs_a   = r_sa ? (~r_a + 1'b1) : r_a;
    assign w_abs_b   = r_sb ? (~r_b + 1'b1) : r_b;
    assign w_unused  = ^{r_rem[WIDTH], inst[24:15], inst[11:7]};

    always_comb begin
        w_spec_val = '0;
        if (r_ill) begin
            w_spec_val = '0;
        end else if (w_dz) begin
            w_spec_val = r_f3[1] ? r_a : '1;
        end else if (w_ovf) begin
            w_spec_val = r_f3[1] ? '0 : r_a;
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div  (w_div),
        .i_a    (r_a),
        .i_b    (r_b),
        .i_prod (r_prod),
        .i_rem  (r_rem),
        .o_prod (w_step_prod),
        .o_rem  (w_step_rem)
    );

    assign w_prod_s = (r_sa ^ r_sb) ? (~r_prod + 1'b1) : r_prod;
    assign w_quo    = (r_sa ^ r_sb) ? (~r_prod[WIDTH-1:0] + 1'b1)
                                    : r_prod[WIDTH-1:0];
    assign w_remv   = r_sa ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];

    always_comb begin
        w_res = r_prod[WIDTH-1:0];
        if (!r_spec) begin
            case (r_f3)
                F3_MUL:                     w_res = w_prod_s[WIDTH-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: w_res = w_prod_s[2*WIDTH-1:WIDTH];
                F3_DIV, F3_DIVU:            w_res = w_quo;
                default:                    w_res = w_remv;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (in_valid) w_nxt = ST_PREP;
            ST_PREP:  w_nxt = w_spec ? ST_FIXUP : ST_BUSY;
            ST_BUSY:  if (r_cnt == CNT_W'(1)) w_nxt = ST_FIXUP;
            ST_FIXUP: w_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_nxt = ST_IDLE;
            default:  w_nxt = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_out  <= '0;
            r_prod <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_f3   <= '0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_ill  <= 1'b0;
            r_spec <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_f3  <= inst[14:12];
                        r_sa  <= signed_a(inst[14:12]) & a[WIDTH-1];
                        r_sb  <= signed_b(inst[14:12]) & b[WIDTH-1];
                        r_ill <= w_ill_dec;
                    end
                end
                ST_PREP: begin
                    r_spec <= w_spec;
                    r_rem  <= '0;
                    r_cnt  <= CNT_W'(WIDTH);
                    // Special results ride through FIXUP in the product low half.
                    if (w_spec) begin
                        r_prod <= {{WIDTH{1'b0}}, w_spec_val};
                    end else begin
                        r_a    <= w_abs_a;
                        r_b    <= w_abs_b;
                        r_prod <= {{WIDTH{1'b0}}, w_div ? w_abs_a : w_abs_b};
                    end
                end
                ST_BUSY: begin
                    r_prod <= w_step_prod;
                    r_rem  <= w_step_rem;
                    r_cnt  <= r_cnt - 1'b1;
                end
                ST_FIXUP: begin
                    if (w_nxt == ST_DONE) begin
                        r_out <= w_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out       = r_out;
    assign z         = (r_out == '0);
    assign n         = r_out[WIDTH-1];
    assign illegal   = r_ill;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed and random ops against
// a 64-bit arithmetic reference, plus backpressure, abort and reset.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] a, b, inst;
    logic        abort;
    logic        out_valid, out_ready;
    logic [31:0] out;
    logic        z, n, illegal, busy;

    typedef struct {
        logic [31:0] val;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic prev_v = 1'b0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .inst(inst), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .z(z), .n(n), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] i,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        logic signed [31:0] sx, sy;
        logic               ovf;
        sx  = x;
        sy  = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        if (i[6:0] != 7'b0110011 || i[31:25] != 7'b0000001)
            return {1'b1, 32'h0};
        case (i[14:12])
            3'd0: begin pu = {32'h0, x} * {32'h0, y}; return {1'b0, pu[31:0]}; end
            3'd1: begin ps = 64'(sx) * 64'(sy); return {1'b0, ps[63:32]}; end
            3'd2: begin ps = 64'(sx) * $signed({32'h0, y}); return {1'b0, ps[63:32]}; end
            3'd3: begin pu = {32'h0, x} * {32'h0, y}; return {1'b0, pu[63:32]}; end
            3'd4: return {1'b0, (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy)};
            3'd5: return {1'b0, (y == 0) ? 32'hFFFF_FFFF : x / y};
            3'd6: return {1'b0, (y == 0) ? x : ovf ? 32'h0 : 32'(sx % sy)};
            default: return {1'b0, (y == 0) ? x : x % y};
        endcase
    endfunction

    function automatic int latency(input logic [31:0] i,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
        logic ill, dv, sdv;
        ill = (i[6:0] != 7'b0110011) || (i[31:25] != 7'b0000001);
        dv  = i[14];
        sdv = i[14] && !i[12];
        if (ill || (dv && y == 0) ||
            (sdv && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))
            return 2;
        return 34;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_v <= 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %h expected none", out);
                end else begin
                    m_e = sb.pop_front();
                    chk("out", out, m_e.val);
                    chk("illegal", 32'(illegal), 32'(m_e.ill));
                    chk("z", 32'(z), 32'(m_e.val == 0));
                    chk("n", 32'(n), 32'(m_e.val[31]));
                    chk("latency", 32'(cyc - m_e.acc), 32'(m_e.lat));
                end
            end
            prev_v <= out_valid;
        end
    end

    task automatic issue(input logic [31:0] i, input logic [31:0] x,
                         input logic [31:0] y, input bit push);
        logic [32:0] r;
        exp_t        e;
        int          k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        inst     = i;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            r     = model(i, x, y);
            e.val = r[31:0];
            e.ill = r[32];
            e.lat = latency(i, x, y);
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb.size() != 0 || !in_ready) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got pending %0d expected 0", sb.size());
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out"}, out, 32'h0);
        chk({tag, "_z"}, 32'(z), 32'd1);
        chk({tag, "_n"}, 32'(n), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    logic [95:0] dir [0:12] = '{
        {32'h0200_0033, 32'h0000_0007, 32'hFFFF_FFFD},
        {32'h0200_3033, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        {32'h0200_1033, 32'h8000_0000, 32'h8000_0000},
        {32'h0200_2033, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        {32'h0200_4033, 32'hFFFF_FFF9, 32'h0000_0002},
        {32'h0200_6033, 32'hFFFF_FFF9, 32'h0000_0002},
        {32'h0200_5033, 32'hFFFF_FFF1, 32'h0000_0010},
        {32'h0200_7033, 32'hFFFF_FFF1, 32'h0000_0010},
        {32'h0200_4033, 32'h0000_0005, 32'h0000_0000},
        {32'h0200_6033, 32'h0000_0005, 32'h0000_0000},
        {32'h0200_4033, 32'h8000_0000, 32'hFFFF_FFFF},
        {32'h0200_6033, 32'h8000_0000, 32'hFFFF_FFFF},
        {32'h0000_0033, 32'h0000_0005, 32'h0000_0006}
    };

    initial begin
        #500000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] r;
        logic [31:0] ri, ra, rb;
        logic [2:0]  f3;
        int          cnt;
        rst       = 1'b1;
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        inst      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outs("reset");

        for (int i = 0; i < 13; i++) begin
            issue(dir[i][95:64], dir[i][63:32], dir[i][31:0], 1'b1);
            wait_idle();
        end

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            ri = {7'b0000001, 5'($urandom), 5'($urandom), f3,
                  5'($urandom), 7'b0110011};
            case ($urandom_range(0, 9))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: ri[31:25] = 7'($urandom_range(2, 127));
                3: ri[6:0] = 7'b0010011;
                4: rb = 32'($urandom_range(1, 255));
                default: ;
            endcase
            issue(ri, ra, rb, 1'b1);
            wait_idle();
        end

        out_ready = 1'b0;
        issue(32'h0200_0033, 32'h0000_1234, 32'h0000_5678, 1'b1);
        r   = model(32'h0200_0033, 32'h0000_1234, 32'h0000_5678);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            inst     = 32'h0200_3033;
            a        = $urandom;
            b        = $urandom;
            in_valid = 1'(k % 2 == 0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out", out, r[31:0]);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        issue(32'h0200_5033, 32'hDEAD_BEEF, 32'h0000_0123, 1'b1);
        wait_idle();

        issue(32'h0200_4033, 32'h1234_5678, 32'h0000_0011, 1'b0);
        repeat (9) @(negedge clk);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("abort_no_out", 32'(cnt), 32'd0);

        issue(32'h0200_0033, 32'hFFFF_0001, 32'h0001_0003, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        issue(32'h0200_0033, 32'd3, 32'd4, 1'b1);
        wait_idle();

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
